// File: rtl/output_spad_writer.sv
// Output scratchpad writer: buffers the router's non-stallable word stream in a
// small FIFO and writes it to sequential scratchpad addresses, pulsing done at the end.
module output_spad_writer #(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = SPAD_ADDR_WIDTH + 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [SPAD_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]       i_word_count,
    input  logic [SPAD_DATA_WIDTH-1:0] i_data,
    input  logic                       i_valid,
    input  logic                       i_spad_ready,
    output logic                       o_spad_wr_en,
    output logic [SPAD_ADDR_WIDTH-1:0] o_spad_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [CNT_WIDTH-1:0]       o_written
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [SPAD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]       target_q, target_d;
    logic [CNT_WIDTH-1:0]       pushed_q, pushed_d;
    logic [CNT_WIDTH-1:0]       written_q, written_d;
    logic                       error_q, error_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic [SPAD_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic active;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        active = (state_q == S_ACTIVE);
        empty  = (occ_q == '0);
        full   = (occ_q == OCC_W'(FIFO_DEPTH));
        pop    = active && !empty && i_spad_ready;
        // A pop frees the head slot in the same edge, so a full FIFO can still accept.
        push   = active && i_valid && (pushed_q < target_q) && (!full || pop);
        drop   = active && i_valid && !push;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        target_d  = target_q;
        pushed_d  = pushed_q;
        written_d = written_q;
        error_d   = error_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d    = i_base_addr;
                    target_d  = i_word_count;
                    pushed_d  = '0;
                    written_d = '0;
                    error_d   = 1'b0;
                    state_d   = (i_word_count == '0) ? S_DONE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (push) begin
                    pushed_d = pushed_q + CNT_WIDTH'(1);
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    addr_d    = addr_q + SPAD_ADDR_WIDTH'(1);
                    written_d = written_q + CNT_WIDTH'(1);
                    if ((written_q + CNT_WIDTH'(1)) == target_q) begin
                        state_d = S_DONE;
                    end
                end
                occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
                if (drop) begin
                    error_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            target_q  <= '0;
            pushed_q  <= '0;
            written_q <= '0;
            error_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            target_q  <= target_d;
            pushed_q  <= pushed_d;
            written_q <= written_d;
            error_q   <= error_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

    // Storage carries no reset; the gated read below hides stale contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_spad_wr_en = !empty;
    assign o_spad_addr  = addr_q;
    assign o_spad_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign o_busy       = active;
    assign o_done       = (state_q == S_DONE);
    assign o_error      = error_q;
    assign o_written    = written_q;

endmodule

// File: tb/tb_output_spad_writer.sv
// Directed bench for output_spad_writer: expected (addr,data) writes are queued at
// stimulus time and compared when the scratchpad port accepts a write.
module tb_output_spad_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base;
    logic [8:0]  cnt;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        wr_en;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  written;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int wr_seen = 0;
    logic [23:0] exp_q [$];
    logic [7:0]  exp_addr;

    output_spad_writer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_word_count (cnt),
        .i_data       (data),
        .i_valid      (valid),
        .i_spad_ready (ready),
        .o_spad_wr_en (wr_en),
        .o_spad_addr  (addr),
        .o_spad_data  (wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_written    (written)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] c);
        base     = b;
        cnt      = c;
        start    = 1'b1;
        exp_addr = b;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input bit accept);
        data  = d;
        valid = 1'b1;
        if (accept) begin
            exp_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 8'd1;
        end
        tick();
        valid = 1'b0;
    endtask

    // Scoreboard side: every accepted write must match the head of the queue.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (!rst && wr_en && ready) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL wr_unexpected got %0h expected none", {addr, wdata});
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                assert ({addr, wdata} === e) else begin
                    errors++;
                    $error("FAIL wr_beat got %0h expected %0h", {addr, wdata}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; cnt = '0;
        data = '0; valid = 1'b0; ready = 1'b0; exp_addr = '0;
        tick();
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_written", written, 0);
        rst = 1'b0;
        tick();

        // Basic transfer, one write per cycle
        ready = 1'b1;
        start_xfer(8'h10, 9'd4);
        chk("t1_busy", busy, 1);
        chk("t1_idle_wr", wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            send(16'hA1B2 + 16'(i) * 16'h0101, 1'b1);
            if (i == 0) chk("t1_latency", wr_en, 1);
        end
        chk("t1_last_wr", wr_en, 1);
        tick();
        chk("t1_done", done, 1);
        chk("t1_written", written, 4);
        chk("t1_error", error, 0);
        chk("t1_busy_off", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Address wrap
        start_xfer(8'hFE, 9'd3);
        for (int i = 0; i < 3; i++) send(16'h5500 + 16'(i), 1'b1);
        tick();
        chk("t2_done", done, 1);
        chk("t2_wrap_addr", addr, 8'h01);
        chk("t2_written", written, 3);
        tick();

        // Overflow with stalled scratchpad
        ready = 1'b0;
        start_xfer(8'h20, 9'd8);
        for (int i = 0; i < 6; i++) send(16'h3000 + 16'(i), i < 4);
        chk("t3_error", error, 1);
        chk("t3_hold_wr", wr_en, 1);
        tick();
        chk("t3_hold_addr", addr, 8'h20);
        chk("t3_hold_data", wdata, 16'h3000);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_written4", written, 4);
        chk("t3_busy", busy, 1);
        chk("t3_no_done", done, 0);
        chk("t3_drained", wr_en, 0);
        for (int i = 0; i < 4; i++) send(16'h3100 + 16'(i), 1'b1);
        tick();
        chk("t3_done", done, 1);
        chk("t3_written8", written, 8);
        chk("t3_error_sticky", error, 1);
        tick();

        // Excess word after target reached
        start_xfer(8'h40, 9'd2);
        chk("t4_error_cleared", error, 0);
        send(16'h4444, 1'b1);
        send(16'h4445, 1'b1);
        send(16'h4446, 1'b0);
        chk("t4_done", done, 1);
        chk("t4_error", error, 1);
        chk("t4_written", written, 2);
        tick();

        // Zero-length transfer, then ignored restart mid-transfer
        start_xfer(8'h33, 9'd0);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_busy", busy, 0);
        chk("t5_zero_written", written, 0);
        chk("t5_error_cleared", error, 0);
        tick();
        chk("t5_zero_pulse", done, 0);
        start_xfer(8'h50, 9'd4);
        send(16'h5050, 1'b1);
        data = 16'h5151; valid = 1'b1;
        start = 1'b1; base = 8'h90; cnt = 9'd2;
        exp_q.push_back({exp_addr, data});
        exp_addr = exp_addr + 8'd1;
        tick();
        start = 1'b0; valid = 1'b0;
        chk("t5_restart_busy", busy, 1);
        send(16'h5252, 1'b1);
        send(16'h5353, 1'b1);
        tick();
        chk("t5_done", done, 1);
        chk("t5_written", written, 4);
        tick();

        // Reset with words buffered
        ready = 1'b0;
        start_xfer(8'h60, 9'd4);
        send(16'h6060, 1'b0);
        send(16'h6161, 1'b0);
        chk("t6_buffered", wr_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_addr", addr, 0);
        chk("t6_rst_data", wdata, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_written", written, 0);
        tick();
        chk("t6_no_done", done, 0);
        ready = 1'b1;
        start_xfer(8'h70, 9'd2);
        send(16'h7070, 1'b1);
        send(16'h7171, 1'b1);
        tick();
        chk("t6_done", done, 1);
        chk("t6_written", written, 2);
        tick();
        tick();

        chk("sb_empty", exp_q.size(), 0);
        chk("done_count", done_seen, 7);
        chk("write_count", wr_seen, 23);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
